net_packet_rx: RTL and testbench

Core-side receiver for the host network packet stream that loads and controls the miner core. Each cycle it samples one `net_packet_s`, filters it by destination ID and decodes `net_op`. INSTR packets become instruction-memory writes. REG packets become register-file writes, buffered against core writeback. BAR packets set the barrier mask. PC packets set the PC and barrier bits and start the core. It sits inside `core_flattened`, between `net_packet_flat_i` and the imem, register file and PC/barrier logic.

---
 rtl/net_packet_rx_pkg.sv | 48 ++++
 rtl/net_packet_rx_reg_write_fifo.sv | 63 ++++++
 rtl/net_packet_rx.sv | 181 ++++++++++++++++++
 tb/tb_net_packet_rx.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/net_packet_rx_pkg.sv
// Shared definitions for the core-side network packet receiver: packet and
// instruction formats, net_op encoding and the receiver FSM state type.
package net_packet_rx_pkg;

    localparam int net_id_width_gp   = 10;
    localparam int net_addr_width_gp = 10;
    localparam int net_data_width_gp = 32;
    localparam int rs_imm_size_gp    = 5;
    localparam int mask_length_gp    = 3;

    // One REG-write buffer entry is {register address, register data}.
    localparam int net_rx_fifo_width_gp = rs_imm_size_gp + net_data_width_gp;

    typedef enum logic [2:0] {
        NULL  = 3'd0,
        INSTR = 3'd1,
        REG   = 3'd2,
        PC    = 3'd3,
        BAR   = 3'd4
    } net_op_e;

    typedef struct packed {
        logic [5:0]                opcode;
        logic [rs_imm_size_gp-1:0] rd;
        logic [rs_imm_size_gp-1:0] rs_imm;
    } instruction_s;

    typedef struct packed {
        logic [net_id_width_gp-1:0]   ID;
        net_op_e                      net_op;
        logic [3:0]                   reserved;
        logic [net_data_width_gp-1:0] net_data;
        logic [net_addr_width_gp-1:0] net_addr;
    } net_packet_s;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        PEND = 2'd1,
        RUN  = 2'd2
    } net_rx_state_e;

    // A packet is ours when it carries our node ID and a non-NULL opcode.
    function automatic logic pkt_accept(input net_packet_s pkt,
                                        input logic [net_id_width_gp-1:0] node_id);
        return (pkt.ID == node_id) && (pkt.net_op != NULL);
    endfunction

endpackage

// File: rtl/net_packet_rx_reg_write_fifo.sv
// Synchronous FIFO buffering register-file writes until the core grants the
// write port. DEPTH_P must be a power of two and at least 2.
module reg_write_fifo #(
    parameter int WIDTH_P = 37,
    parameter int DEPTH_P = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic [WIDTH_P-1:0] data_i,
    input  logic               pop_i,
    output logic [WIDTH_P-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int AW = $clog2(DEPTH_P);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [AW:0]        wptr_q, wptr_d;
    logic [AW:0]        rptr_q, rptr_d;
    logic               push_ok;
    logic               pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    assign data_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/net_packet_rx.sv
// Core-side network packet receiver: imem loads, buffered register writes,
// barrier mask and PC start control. Optional accepted-packet counter: NET_RX_PKT_COUNT_EN.
module net_packet_rx
    import net_packet_rx_pkg::*;
#(
    parameter logic [net_id_width_gp-1:0] ID_P         = 10'b0000000001,
    parameter int                         FIFO_DEPTH_P = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  net_packet_s                   net_packet_i,
    output logic                          imem_wen_o,
    output logic [net_addr_width_gp-1:0]  imem_addr_o,
    output instruction_s                  imem_data_o,
    input  logic                          rf_gnt_i,
    output logic                          rf_wen_o,
    output logic [rs_imm_size_gp-1:0]     rf_addr_o,
    output logic [net_data_width_gp-1:0]  rf_data_o,
    output logic                          pc_wen_o,
    output logic [net_addr_width_gp-1:0]  pc_o,
    output logic [mask_length_gp-1:0]     barrier_o,
    output logic [mask_length_gp-1:0]     barrier_mask_o,
    output logic                          core_run_o,
    output logic                          overflow_o,
    output logic [31:0]                   pkt_count_o
);

    localparam int INSTR_W = $bits(instruction_s);
    localparam int FIFO_W  = net_rx_fifo_width_gp;

    logic accept;
    logic is_instr;
    logic is_reg;
    logic is_pc;
    logic is_bar;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_wdata;
    logic [FIFO_W-1:0] fifo_rdata;

    logic                         imem_wen_q;
    logic [net_addr_width_gp-1:0] imem_addr_q;
    instruction_s                 imem_data_q;
    logic [mask_length_gp-1:0]    barrier_mask_q;
    logic                         overflow_q;

    net_rx_state_e                state_q;
    logic                         pc_wen_q;
    logic                         core_run_q;
    logic [net_addr_width_gp-1:0] pc_q;
    logic [mask_length_gp-1:0]    barrier_q;

    logic unused_reserved;

    assign accept   = pkt_accept(net_packet_i, ID_P);
    assign is_instr = accept && (net_packet_i.net_op == INSTR);
    assign is_reg   = accept && (net_packet_i.net_op == REG);
    assign is_pc    = accept && (net_packet_i.net_op == PC);
    assign is_bar   = accept && (net_packet_i.net_op == BAR);

    assign unused_reserved = ^net_packet_i.reserved;

    // RF write handshake: rf_wen_o = head valid & rf_gnt_i; the head is
    // written and popped on the same edge, and a full FIFO still takes a
    // push in a cycle that pops.
    assign fifo_pop   = !fifo_empty && rf_gnt_i;
    assign fifo_push  = is_reg && (!fifo_full || fifo_pop);
    assign fifo_wdata = {net_packet_i.net_addr[rs_imm_size_gp-1:0], net_packet_i.net_data};

    reg_write_fifo #(
        .WIDTH_P (FIFO_W),
        .DEPTH_P (FIFO_DEPTH_P)
    ) u_reg_write_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rf_wen_o  = fifo_pop;
    assign rf_addr_o = fifo_rdata[FIFO_W-1:net_data_width_gp];
    assign rf_data_o = fifo_rdata[net_data_width_gp-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            imem_wen_q     <= 1'b0;
            imem_addr_q    <= '0;
            imem_data_q    <= '0;
            barrier_mask_q <= '0;
            overflow_q     <= 1'b0;
        end else begin
            imem_wen_q <= is_instr;
            if (is_instr) begin
                imem_addr_q <= net_packet_i.net_addr;
                imem_data_q <= instruction_s'(net_packet_i.net_data[INSTR_W-1:0]);
            end
            if (is_bar) begin
                barrier_mask_q <= net_packet_i.net_data[mask_length_gp-1:0];
            end
            if (is_reg && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // The PC load is held in PEND until every buffered register write has
    // drained and no new REG packet is arriving, so the core never starts
    // with stale registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= HALT;
            pc_wen_q   <= 1'b0;
            core_run_q <= 1'b0;
            pc_q       <= '0;
            barrier_q  <= '0;
        end else begin
            pc_wen_q <= 1'b0;
            if (is_pc) begin
                pc_q       <= net_packet_i.net_addr;
                barrier_q  <= net_packet_i.net_data[mask_length_gp-1:0];
                core_run_q <= 1'b0;
                state_q    <= PEND;
            end else begin
                case (state_q)
                    HALT: begin
                        core_run_q <= 1'b0;
                    end
                    PEND: begin
                        if (fifo_empty && !is_reg) begin
                            pc_wen_q   <= 1'b1;
                            core_run_q <= 1'b1;
                            state_q    <= RUN;
                        end
                    end
                    RUN: begin
                        core_run_q <= 1'b1;
                    end
                    default: begin
                        core_run_q <= 1'b0;
                        state_q    <= HALT;
                    end
                endcase
            end
        end
    end

    assign imem_wen_o     = imem_wen_q;
    assign imem_addr_o    = imem_addr_q;
    assign imem_data_o    = imem_data_q;
    assign barrier_mask_o = barrier_mask_q;
    assign overflow_o     = overflow_q;
    assign pc_wen_o       = pc_wen_q;
    assign core_run_o     = core_run_q;
    assign pc_o           = pc_q;
    assign barrier_o      = barrier_q;

`ifdef NET_RX_PKT_COUNT_EN
    // Dropped REG packets were still accepted, so they count too.
    logic [31:0] pkt_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pkt_count_q <= '0;
        end else if (accept) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count_o = pkt_count_q;
`else
    assign pkt_count_o = '0;
`endif

endmodule

// File: tb/tb_net_packet_rx.sv
// Self-checking bench for net_packet_rx: vector table for filtering/decode,
// scoreboarded imem and register writes, hand sequences for PC/reset corners.
module tb_net_packet_rx;
  import net_packet_rx_pkg::*;

  localparam logic [9:0] NODE_ID = 10'd1;
  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  net_packet_s  pkt;
  logic         rf_gnt;
  logic         imem_wen_o;
  logic [9:0]   imem_addr_o;
  instruction_s imem_data_o;
  logic         rf_wen_o;
  logic [4:0]   rf_addr_o;
  logic [31:0]  rf_data_o;
  logic         pc_wen_o;
  logic [9:0]   pc_o;
  logic [2:0]   barrier_o;
  logic [2:0]   barrier_mask_o;
  logic         core_run_o;
  logic         overflow_o;
  logic [31:0]  pkt_count_o;

  net_packet_rx #(.ID_P(NODE_ID), .FIFO_DEPTH_P(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .net_packet_i   (pkt),
    .imem_wen_o     (imem_wen_o),
    .imem_addr_o    (imem_addr_o),
    .imem_data_o    (imem_data_o),
    .rf_gnt_i       (rf_gnt),
    .rf_wen_o       (rf_wen_o),
    .rf_addr_o      (rf_addr_o),
    .rf_data_o      (rf_data_o),
    .pc_wen_o       (pc_wen_o),
    .pc_o           (pc_o),
    .barrier_o      (barrier_o),
    .barrier_mask_o (barrier_mask_o),
    .core_run_o     (core_run_o),
    .overflow_o     (overflow_o),
    .pkt_count_o    (pkt_count_o)
  );

  // scoreboard state
  int total = 0;
  int bad = 0;
  logic [36:0] rf_exp_q[$];
  logic [25:0] imem_exp_q[$];
  int m_occ = 0;
  int m_cnt = 0;
  int rf_writes = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // driver: present one packet for one cycle, updating the reference model
  task automatic cycle(input logic [9:0] id, input net_op_e op, input logic [31:0] data,
                       input logic [9:0] addr, input logic gnt);
    logic pop;
    logic acc;
    pkt.ID       = id;
    pkt.net_op   = op;
    pkt.reserved = 4'($urandom_range(0, 15));
    pkt.net_data = data;
    pkt.net_addr = addr;
    rf_gnt       = gnt;
    pop = (m_occ > 0) && gnt;
    acc = (id == NODE_ID) && (op != NULL);
    if (acc) m_cnt++;
    if (acc && op == INSTR) imem_exp_q.push_back({addr, data[15:0]});
    if (acc && op == REG && (m_occ < DEPTH || pop)) begin
      rf_exp_q.push_back({addr[4:0], data});
      m_occ++;
    end
    if (pop) m_occ--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic gnt);
    repeat (n) cycle(10'd0, NULL, 32'd0, 10'd0, gnt);
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    pkt    = '0;
    rf_gnt = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rf_exp_q.delete();
    imem_exp_q.delete();
    m_occ = 0;
    m_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_wen"}, imem_wen_o, 0);
    check({tag, "_imem_addr"}, imem_addr_o, 0);
    check({tag, "_imem_data"}, imem_data_o, 0);
    check({tag, "_pc_wen"}, pc_wen_o, 0);
    check({tag, "_pc"}, pc_o, 0);
    check({tag, "_barrier"}, barrier_o, 0);
    check({tag, "_barrier_mask"}, barrier_mask_o, 0);
    check({tag, "_core_run"}, core_run_o, 0);
    check({tag, "_overflow"}, overflow_o, 0);
    check({tag, "_pkt_count"}, pkt_count_o, 0);
    check({tag, "_rf_addr"}, rf_addr_o, 0);
    check({tag, "_rf_data"}, rf_data_o, 0);
    rf_gnt = 1'b1;
    #1;
    check({tag, "_rf_wen_empty"}, rf_wen_o, 0);
    rf_gnt = 1'b0;
  endtask

  // output monitor: every write strobe must match the scoreboard head
  always @(negedge clk) begin
    logic [36:0] rf_e;
    logic [25:0] im_e;
    if (mon_en) begin
      if (rf_wen_o) begin
        rf_writes++;
        if (rf_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rf_unexpected: got addr=%0d data=0x%0h want no write", rf_addr_o, rf_data_o);
        end else begin
          rf_e = rf_exp_q.pop_front();
          check("rf_write", {rf_addr_o, rf_data_o}, rf_e);
        end
      end
      if (imem_wen_o) begin
        if (imem_exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL imem_unexpected: got addr=%0d want no write", imem_addr_o);
        end else begin
          im_e = imem_exp_q.pop_front();
          check("imem_write", {imem_addr_o, imem_data_o}, im_e);
        end
      end
    end
  end

  typedef struct {
    logic [9:0]  id;
    net_op_e     op;
    logic [31:0] data;
    logic [9:0]  addr;
    logic        exp_wen;
    logic [9:0]  exp_addr;
    logic [15:0] exp_data;
    logic [2:0]  exp_mask;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int base;
    int exp_cnt;

    vecs[0] = '{10'd2, INSTR, 32'h0000_1234, 10'd5,   1'b0, 10'd0,   16'h0000, 3'd0};
    vecs[1] = '{10'd1, INSTR, 32'h0000_1234, 10'd5,   1'b1, 10'd5,   16'h1234, 3'd0};
    vecs[2] = '{10'd1, NULL,  32'hFFFF_FFFE, 10'd7,   1'b0, 10'd0,   16'h0000, 3'd0};
    vecs[3] = '{10'd1, BAR,   32'h0000_0007, 10'd0,   1'b0, 10'd0,   16'h0000, 3'd7};
    vecs[4] = '{10'd3, BAR,   32'h0000_0002, 10'd0,   1'b0, 10'd0,   16'h0000, 3'd7};
    vecs[5] = '{10'd1, INSTR, 32'hDEAD_BEEF, 10'h3FF, 1'b1, 10'h3FF, 16'hBEEF, 3'd7};
    vecs[6] = '{10'd1, BAR,   32'hFFFF_FFF5, 10'd0,   1'b0, 10'd0,   16'h0000, 3'd5};
    vecs[7] = '{10'd1, NULL,  32'h0000_0000, 10'd0,   1'b0, 10'd0,   16'h0000, 3'd5};

    pkt    = '0;
    rf_gnt = 1'b0;
    do_reset();
    mon_en = 1'b1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // filtering and decode table
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].id, vecs[i].op, vecs[i].data, vecs[i].addr, 1'b1);
      check($sformatf("vec%0d_imem_wen", i), imem_wen_o, vecs[i].exp_wen);
      if (vecs[i].exp_wen) begin
        check($sformatf("vec%0d_imem_addr", i), imem_addr_o, vecs[i].exp_addr);
        check($sformatf("vec%0d_imem_data", i), imem_data_o, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_mask", i), barrier_mask_o, vecs[i].exp_mask);
    end
    check("table_core_run", core_run_o, 0);

    // REG ordering, grant held high: writes on consecutive cycles
    base = rf_writes;
    cycle(10'd1, REG, 32'h56f6950a, 10'd1, 1'b1);
    cycle(10'd1, REG, 32'ha24c2683, 10'd9, 1'b1);
    check("reg_first_write", rf_writes, base + 1);
    idle(1, 1'b1);
    check("reg_second_write", rf_writes, base + 2);
    check("reg_drained", rf_exp_q.size(), 0);

    // REG ordering with three cycles of no grant
    base = rf_writes;
    cycle(10'd1, REG, 32'h56f6950a, 10'd1, 1'b0);
    cycle(10'd1, REG, 32'ha24c2683, 10'd9, 1'b0);
    idle(1, 1'b0);
    check("bp_held", rf_writes, base);
    idle(3, 1'b1);
    check("bp_released", rf_writes, base + 2);
    check("bp_drained", rf_exp_q.size(), 0);

    // overflow: fifth REG with no grant is dropped
    for (int i = 0; i < 5; i++) begin
      cycle(10'd1, REG, $urandom, 10'(10 + i), 1'b0);
      if (i == 3) check("ovf_not_yet", overflow_o, 0);
    end
    check("ovf_set", overflow_o, 1);
    base = rf_writes;
    idle(6, 1'b1);
    check("ovf_four_writes", rf_writes, base + 4);
    check("ovf_drained", rf_exp_q.size(), 0);
    check("ovf_sticky", overflow_o, 1);

    // full with simultaneous pop still accepts the push
    for (int i = 0; i < 4; i++) cycle(10'd1, REG, $urandom, 10'(i), 1'b0);
    base = rf_writes;
    cycle(10'd1, REG, 32'hCAFE_0005, 10'd17, 1'b1);
    idle(5, 1'b1);
    check("full_pop_writes", rf_writes, base + 5);
    check("full_pop_drained", rf_exp_q.size(), 0);

    // PC waits for the r20 write to drain
    cycle(10'd1, REG, 32'd2, 10'd20, 1'b0);
    cycle(10'd1, PC, 32'd2, 10'd0, 1'b0);
    check("pend_pc_wen0", pc_wen_o, 0);
    check("pend_run0", core_run_o, 0);
    idle(1, 1'b0);
    check("pend_pc_wen1", pc_wen_o, 0);
    base = rf_writes;
    idle(1, 1'b1);
    check("pend_r20_written", rf_writes, base + 1);
    check("pend_pc_wen2", pc_wen_o, 0);
    idle(1, 1'b1);
    check("drain_pc_wen", pc_wen_o, 1);
    check("drain_pc", pc_o, 0);
    check("drain_barrier", barrier_o, 3'b010);
    check("drain_run", core_run_o, 1);
    idle(1, 1'b1);
    check("drain_pc_wen_pulse", pc_wen_o, 0);
    check("drain_run_hold", core_run_o, 1);

    // BAR, then PC while running
    cycle(10'd1, BAR, 32'd7, 10'd0, 1'b1);
    check("bar_mask", barrier_mask_o, 3'b111);
    cycle(10'd1, PC, 32'd5, 10'h155, 1'b1);
    check("run_pc_run0", core_run_o, 0);
    check("run_pc_wen0", pc_wen_o, 0);
    idle(1, 1'b1);
    check("run_pc_wen1", pc_wen_o, 1);
    check("run_pc_run1", core_run_o, 1);
    check("run_pc_val", pc_o, 10'h155);
    check("run_pc_barrier", barrier_o, 3'd5);
    idle(1, 1'b1);
    check("run_pc_wen_end", pc_wen_o, 0);

    // a second PC in PEND overwrites the latched values
    cycle(10'd1, REG, 32'h0BAD_F00D, 10'd3, 1'b0);
    cycle(10'd1, PC, 32'd1, 10'h010, 1'b0);
    cycle(10'd1, PC, 32'd6, 10'h020, 1'b0);
    check("ovr_pc", pc_o, 10'h020);
    check("ovr_barrier", barrier_o, 3'd6);
    check("ovr_run", core_run_o, 0);
    idle(1, 1'b1);
    check("ovr_pc_wen_wait", pc_wen_o, 0);
    idle(1, 1'b1);
    check("ovr_pc_wen", pc_wen_o, 1);
    check("ovr_pc_final", pc_o, 10'h020);

    // REG arriving in PEND on an empty FIFO delays the PC load
    cycle(10'd1, PC, 32'd3, 10'h030, 1'b1);
    cycle(10'd1, REG, 32'h1111_2222, 10'd4, 1'b1);
    check("pend_reg_wen0", pc_wen_o, 0);
    idle(1, 1'b1);
    check("pend_reg_wen1", pc_wen_o, 0);
    idle(1, 1'b1);
    check("pend_reg_wen2", pc_wen_o, 1);
    check("pend_reg_queue", rf_exp_q.size(), 0);

    // reset while PEND with two buffered writes
    cycle(10'd1, REG, 32'h5555_0005, 10'd5, 1'b0);
    cycle(10'd1, REG, 32'h6666_0006, 10'd6, 1'b0);
    cycle(10'd1, PC, 32'd4, 10'h044, 1'b0);
    check("mid_pend_run", core_run_o, 0);
    do_reset();
    check_reset_outputs("midreset");
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      check($sformatf("post_reset_pc_wen%0d", i), pc_wen_o, 0);
      check($sformatf("post_reset_run%0d", i), core_run_o, 0);
    end

    // accepted-packet counter: 10 accepted among 13
    for (int i = 0; i < 13; i++) begin
      if (i % 4 == 3) cycle(10'd5, INSTR, $urandom, 10'(i), 1'b1);
      else if (i % 3 == 0) cycle(10'd1, INSTR, $urandom, 10'(i), 1'b1);
      else if (i % 3 == 1) cycle(10'd1, BAR, $urandom, 10'(i), 1'b1);
      else cycle(10'd1, REG, $urandom, 10'(i), 1'b1);
    end
    idle(2, 1'b1);
`ifdef NET_RX_PKT_COUNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("pkt_count", pkt_count_o, exp_cnt);
    check("final_rf_queue", rf_exp_q.size(), 0);
    check("final_imem_queue", imem_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

endmodule
